// File: rtl/id_rf_scoreboard.sv
// rtl/id_rf_scoreboard.sv - decode-stage register file with pending-write scoreboard and stall generation.
// Optional SB_TIMEOUT_EN: flags and force-clears entries whose writeback never arrives.
module id_rf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LAT_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] rd1_addr_i,
  input  logic [ADDR_W-1:0] rd2_addr_i,
  input  logic              rd1_use_i,
  input  logic              rd2_use_i,
  output logic [DATA_W-1:0] rd1_data_o,
  output logic [DATA_W-1:0] rd2_data_o,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_dst_i,
  input  logic [LAT_W-1:0]  issue_lat_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              stall_o,
  output logic [ADDR_W:0]   pending_cnt_o,
  output logic              sb_err_o
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [LAT_W-1:0]  cnt_q [NUM_REGS];
  logic [LAT_W-1:0]  cnt_d [NUM_REGS];
  logic [ADDR_W:0]   pending_q, pending_d;

  logic wb_live;
  logic raw1, raw2, waw;
  logic issue_acc;

  assign wb_live = wb_en_i && (wb_addr_i != '0);

  // Write-through bypass: a same-cycle writeback is visible to the reader.
  assign rd1_data_o = (rd1_addr_i == '0) ? '0 :
                      (wb_live && wb_addr_i == rd1_addr_i) ? wb_data_i : regs_q[rd1_addr_i];
  assign rd2_data_o = (rd2_addr_i == '0) ? '0 :
                      (wb_live && wb_addr_i == rd2_addr_i) ? wb_data_i : regs_q[rd2_addr_i];

  assign raw1 = rd1_use_i && (rd1_addr_i != '0) && busy_q[rd1_addr_i] &&
                !(wb_en_i && wb_addr_i == rd1_addr_i);
  assign raw2 = rd2_use_i && (rd2_addr_i != '0) && busy_q[rd2_addr_i] &&
                !(wb_en_i && wb_addr_i == rd2_addr_i);
  assign waw  = issue_valid_i && (issue_dst_i != '0) && busy_q[issue_dst_i] &&
                !(wb_en_i && wb_addr_i == issue_dst_i);

  assign stall_o   = raw1 || raw2 || waw;
  assign issue_acc = issue_valid_i && !stall_o && (issue_dst_i != '0);

`ifdef SB_TIMEOUT_EN
  logic [NUM_REGS-1:0] late_q, late_d;
  logic                err_q, err_d;
`endif

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
    end
`ifdef SB_TIMEOUT_EN
    late_d = late_q;
    err_d  = err_q;
`endif
    for (int i = 1; i < NUM_REGS; i++) begin
      // Issue outranks a same-cycle writeback to the same entry.
      if (issue_acc && issue_dst_i == ADDR_W'(i)) begin
        busy_d[i] = 1'b1;
        cnt_d[i]  = issue_lat_i;
`ifdef SB_TIMEOUT_EN
        late_d[i] = 1'b0;
`endif
      end else if (wb_live && wb_addr_i == ADDR_W'(i)) begin
        busy_d[i] = 1'b0;
        cnt_d[i]  = '0;
`ifdef SB_TIMEOUT_EN
        late_d[i] = 1'b0;
`endif
      end else if (busy_q[i]) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
`ifdef SB_TIMEOUT_EN
        // DUE with the expected writeback missed; one more miss times out.
        else if (late_q[i]) begin
          busy_d[i] = 1'b0;
          late_d[i] = 1'b0;
          err_d     = 1'b1;
        end else begin
          late_d[i] = 1'b1;
        end
`endif
      end
    end
    pending_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pending_d = pending_d + (ADDR_W+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      if (wb_live) begin
        regs_q[wb_addr_i] <= wb_data_i;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

`ifdef SB_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      late_q <= '0;
      err_q  <= 1'b0;
    end else begin
      late_q <= late_d;
      err_q  <= err_d;
    end
  end
  assign sb_err_o = err_q;
`else
  assign sb_err_o = 1'b0;
`endif

  assign pending_cnt_o = pending_q;

endmodule

// File: tb/tb_id_rf_scoreboard.sv
// tb/tb_id_rf_scoreboard.sv - directed self-checking bench for id_rf_scoreboard.
module tb_id_rf_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  rd1_addr_i, rd2_addr_i;
  logic        rd1_use_i, rd2_use_i;
  logic [31:0] rd1_data_o, rd2_data_o;
  logic        issue_valid_i;
  logic [4:0]  issue_dst_i;
  logic [1:0]  issue_lat_i;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        stall_o;
  logic [5:0]  pending_cnt_o;
  logic        sb_err_o;

  int n_checks = 0;
  int n_pass   = 0;

  id_rf_scoreboard dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rd1_addr_i(rd1_addr_i), .rd2_addr_i(rd2_addr_i),
    .rd1_use_i(rd1_use_i), .rd2_use_i(rd2_use_i),
    .rd1_data_o(rd1_data_o), .rd2_data_o(rd2_data_o),
    .issue_valid_i(issue_valid_i), .issue_dst_i(issue_dst_i), .issue_lat_i(issue_lat_i),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .stall_o(stall_o), .pending_cnt_o(pending_cnt_o), .sb_err_o(sb_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    rd1_addr_i = 5'd0; rd2_addr_i = 5'd0; rd1_use_i = 1'b0; rd2_use_i = 1'b0;
    issue_valid_i = 1'b0; issue_dst_i = 5'd0; issue_lat_i = 2'd0;
    wb_en_i = 1'b0; wb_addr_i = 5'd0; wb_data_i = 32'd0;
    step(); step();
    rst_i = 1'b0;

    // Reset state
    rd1_addr_i = 5'd1; rd2_addr_i = 5'd2; rd1_use_i = 1'b1; rd2_use_i = 1'b1; #1;
    check("rst_rd1", rd1_data_o, 32'd0);
    check("rst_rd2", rd2_data_o, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_pend", {26'd0, pending_cnt_o}, 32'd0);
    check("rst_err", {31'd0, sb_err_o}, 32'd0);

    // Bypass, stored value, r0 write ignored
    wb_en_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'hDEADBEEF; rd1_addr_i = 5'd5; #1;
    check("bypass_r5", rd1_data_o, 32'hDEADBEEF);
    step();
    wb_en_i = 1'b0; #1;
    check("stored_r5", rd1_data_o, 32'hDEADBEEF);
    wb_en_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'h1234; rd1_addr_i = 5'd0; #1;
    check("r0_bypass", rd1_data_o, 32'd0);
    step();
    wb_en_i = 1'b0; #1;
    check("r0_stored", rd1_data_o, 32'd0);

    // RAW on load result, resolved by same-cycle writeback
    rd1_use_i = 1'b0; rd2_use_i = 1'b0;
    issue_valid_i = 1'b1; issue_dst_i = 5'd8; issue_lat_i = 2'd2; #1;
    check("issue8_nostall", {31'd0, stall_o}, 32'd0);
    step();
    issue_valid_i = 1'b0; rd2_addr_i = 5'd8; rd2_use_i = 1'b1; #1;
    check("raw2_stall", {31'd0, stall_o}, 32'd1);
    check("pend_1", {26'd0, pending_cnt_o}, 32'd1);
    step();
    check("raw2_stall_hold", {31'd0, stall_o}, 32'd1);
    wb_en_i = 1'b1; wb_addr_i = 5'd8; wb_data_i = 32'h55; #1;
    check("wb_resolves", {31'd0, stall_o}, 32'd0);
    check("wb_bypass_rd2", rd2_data_o, 32'h55);
    step();
    wb_en_i = 1'b0; #1;
    check("pend_0", {26'd0, pending_cnt_o}, 32'd0);
    check("stored_r8", rd2_data_o, 32'h55);

    // WAW and RD_USE gating
    rd2_use_i = 1'b0;
    issue_valid_i = 1'b1; issue_dst_i = 5'd8; issue_lat_i = 2'd3; #1;
    check("issue8b_ok", {31'd0, stall_o}, 32'd0);
    step();
    issue_lat_i = 2'd1; #1;
    check("waw_stall", {31'd0, stall_o}, 32'd1);
    step();
    check("waw_no_extra", {26'd0, pending_cnt_o}, 32'd1);
    issue_valid_i = 1'b0; rd1_addr_i = 5'd8; rd1_use_i = 1'b0; #1;
    check("nouse_nostall", {31'd0, stall_o}, 32'd0);
    rd1_use_i = 1'b1; #1;
    check("raw1_stall", {31'd0, stall_o}, 32'd1);
    wb_en_i = 1'b1; wb_addr_i = 5'd8; wb_data_i = 32'h0; #1;
    check("raw1_wb_clear", {31'd0, stall_o}, 32'd0);
    step();
    wb_en_i = 1'b0; rd1_use_i = 1'b0; #1;
    check("pend_0b", {26'd0, pending_cnt_o}, 32'd0);

    // Same-cycle issue and writeback to r3: issue wins, data written
    issue_valid_i = 1'b1; issue_dst_i = 5'd3; issue_lat_i = 2'd1;
    wb_en_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'hA5A5A5A5; #1;
    check("iss_wb_ok", {31'd0, stall_o}, 32'd0);
    step();
    issue_valid_i = 1'b0; wb_en_i = 1'b0; rd1_addr_i = 5'd3; #1;
    check("iss_wb_pend", {26'd0, pending_cnt_o}, 32'd1);
    check("iss_wb_data", rd1_data_o, 32'hA5A5A5A5);
    rd1_use_i = 1'b1; #1;
    check("iss_wb_busy", {31'd0, stall_o}, 32'd1);

    // Reset mid-operation drops pending entries
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; #1;
    check("midrst_pend", {26'd0, pending_cnt_o}, 32'd0);
    check("midrst_stall", {31'd0, stall_o}, 32'd0);
    check("midrst_r3", rd1_data_o, 32'd0);
    wb_en_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'h77;
    step();
    wb_en_i = 1'b0; #1;
    check("post_rst_wb", rd1_data_o, 32'h77);
    check("post_rst_pend", {26'd0, pending_cnt_o}, 32'd0);
    check("err_default", {31'd0, sb_err_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_rf_scoreboard.md
Name: id_rf_scoreboard

Overview:
- Parametrised decode-stage register file with a built-in pending-write scoreboard.
- Provides two bypassed read ports and one writeback port.
- Tracks destination registers of in-flight multi-cycle producers (loads, long ALU ops) and raises a stall when a source or destination is still pending.
- Replaces the fixed 32x32 file plus separate load-use hazard logic in the ID stage.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W.
- LAT_W, 2, width of the issue-latency field; maximum latency is 2**LAT_W-1 cycles.

Ports:
- CLOCK  in  1  system clock, all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- RD1_ADDR  in  ADDR_W  read port 1 address (Rs).
- RD2_ADDR  in  ADDR_W  read port 2 address (Rt).
- RD1_USE  in  1  instruction consumes RD1.
- RD2_USE  in  1  instruction consumes RD2.
- RD1_DATA  out  DATA_W  read data 1, combinational.
- RD2_DATA  out  DATA_W  read data 2, combinational.
- ISSUE_VALID  in  1  ID instruction produces a result.
- ISSUE_DST  in  ADDR_W  destination register of issuing instruction.
- ISSUE_LAT  in  LAT_W  expected cycles until writeback.
- WB_EN  in  1  writeback strobe.
- WB_ADDR  in  ADDR_W  writeback address.
- WB_DATA  in  DATA_W  writeback data.
- STALL  out  1  hold PC/IFID and zero control, combinational.
- PENDING_CNT  out  ADDR_W+1  number of registers currently busy, registered.
- SB_ERR  out  1  sticky scoreboard timeout flag (SB_TIMEOUT_EN builds only; tied 0 otherwise).

Behaviour:
- Reset, synchronous, active-high:
  - All registers are cleared to 0.
  - All busy bits and counters are cleared to 0.
  - PENDING_CNT=0 and SB_ERR=0.
  - STALL evaluates to 0 because nothing is busy.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored.
  - It is never marked busy.
- Writeback:
  - When WB_EN=1 and WB_ADDR!=0, the register is written at the clock edge.
  - The same edge clears busy[WB_ADDR].
- Read:
  - RDn_DATA = WB_DATA when WB_EN=1, WB_ADDR==RDn_ADDR and RDn_ADDR!=0 (write-through bypass).
  - Otherwise RDn_DATA is the stored value.
  - Read latency is 0 cycles.
- Scoreboard state per register: a busy bit and a LAT_W-bit countdown.
- Accepted issue:
  - An issue is accepted when ISSUE_VALID=1, STALL=0 and ISSUE_DST!=0.
  - Acceptance sets busy[ISSUE_DST]=1 and cnt=ISSUE_LAT.
  - ISSUE_LAT=0 is legal and means writeback is expected in the next cycle.
- Countdown: each cycle, every busy register with cnt>0 decrements; cnt saturates at 0.
- Simultaneous accepted issue and WB_EN to the same register:
  - Issue wins: busy stays 1 and cnt is reloaded.
  - The data write still occurs.
- STALL = RAW1 | RAW2 | WAW, where:
  - RAWn = RDn_USE & busy[RDn_ADDR] & !(WB_EN & WB_ADDR==RDn_ADDR). A same-cycle writeback resolves the hazard via the bypass.
  - WAW = ISSUE_VALID & busy[ISSUE_DST] & !(WB_EN & WB_ADDR==ISSUE_DST).
  - Terms addressing r0 never assert.
- Issue while STALL=1 is ignored, with no scoreboard change; the upstream stage re-presents the instruction.
- PENDING_CNT is the registered popcount of the busy vector after the edge's updates; it is updated every cycle.
- Reset asserted mid-operation:
  - Pending entries are dropped.
  - A writeback arriving after reset release writes data normally; clearing an already-clear busy bit is a no-op.
- No internal FSM beyond the per-entry states IDLE (busy=0), WAIT (busy=1, cnt>0) and DUE (busy=1, cnt=0).
- Entry transitions:
  - IDLE->WAIT/DUE on issue.
  - WAIT->DUE when the countdown reaches 0.
  - Any state->IDLE on writeback without a same-cycle issue.

Optional Feature:
- Macro: SB_TIMEOUT_EN.
- Defined:
  - A busy entry in DUE that sees no writeback for one further cycle sets SB_ERR=1 (sticky until RESET).
  - The busy bit is then force-cleared to avoid deadlock.
- Undefined:
  - SB_ERR is tied 0.
  - DUE entries wait indefinitely for writeback.
  - No extra logic is built.

Test Plan:
- Reset then read r1/r2 with USE=1 -> RD1_DATA=RD2_DATA=0, STALL=0, PENDING_CNT=0.
- WB_EN=1, WB_ADDR=5, WB_DATA=0xDEADBEEF, same cycle RD1_ADDR=5 -> RD1_DATA=0xDEADBEEF (bypass); next cycle stored value 0xDEADBEEF; write to r0 with 0x1234 -> r0 still reads 0.
- Issue dst=8, LAT=2; next cycle RD2_ADDR=8, RD2_USE=1 -> STALL=1, PENDING_CNT=1; WB r8=0x55 two cycles later -> STALL=0 in the WB cycle, RD2_DATA=0x55, PENDING_CNT=0 after the edge.
- Issue dst=8 while r8 busy -> STALL=1 (WAW), cnt unchanged; RD1_USE=0 with busy r8 on RD1_ADDR -> no stall.
- Same cycle: accepted issue dst=3, LAT=1 and WB r3 -> r3 written, busy[3]=1, PENDING_CNT=1.
- SB_TIMEOUT_EN: issue dst=4, LAT=0, no WB for 2 cycles -> SB_ERR=1, busy[4] cleared, PENDING_CNT=0; SB_ERR holds until RESET.
